// File: rtl/apb_pkg.sv
// apb_pkg: APB state encoding and strobe-width helper, shared by requester and slave side.
package apb_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10,
    RESP   = 2'b11
  } apb_state_t;
  function automatic int apb_strb_w(input int dw);
    return dw / 8;
  endfunction
endpackage

// File: rtl/apb_master.sv
// apb_master: APB4 requester turning a valid/ready command stream into SETUP/ACCESS
// transfers with wait states, slave errors and an ACCESS-phase watchdog.
module apb_master
  import apb_pkg::*;
#(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int TMO = 16,
  localparam int SW = apb_strb_w(DW)
) (
  input  logic          pclk,
  input  logic          preset,
  input  logic          i_cmd_valid,
  output logic          o_cmd_ready,
  input  logic          i_cmd_write,
  input  logic [AW-1:0] i_cmd_addr,
  input  logic [DW-1:0] i_cmd_wdata,
  input  logic [SW-1:0] i_cmd_strb,
  output logic          o_rsp_valid,
  input  logic          i_rsp_ready,
  output logic [DW-1:0] o_rsp_rdata,
  output logic          o_rsp_err,
  output logic          o_rsp_tmo,
  output logic [AW-1:0] o_paddr,
  output logic          o_pwrite,
  output logic          o_psel,
  output logic          o_penable,
  output logic [DW-1:0] o_pwdata,
  output logic [SW-1:0] o_pstrb,
  input  logic [DW-1:0] i_prdata,
  input  logic          i_pslverr,
  input  logic          i_pready
);
  localparam int CW = $clog2(TMO);
  localparam logic [CW-1:0] CNT_LAST = CW'(TMO - 1);

  apb_state_t    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          write_q, write_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [SW-1:0] strb_q, strb_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          tmo_q, tmo_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end

  // Write data and strobe are zeroed at capture so reads never show stale bus data.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (i_cmd_valid) begin
        state_d = SETUP;
        addr_d  = i_cmd_addr;
        write_d = i_cmd_write;
        wdata_d = i_cmd_write ? i_cmd_wdata : '0;
        strb_d  = i_cmd_write ? i_cmd_strb : '0;
        cnt_d   = '0;
      end
      SETUP: state_d = ACCESS;
      ACCESS: if (i_pready) begin
        state_d = RESP;
        err_d   = i_pslverr;
        tmo_d   = 1'b0;
        rdata_d = write_q ? '0 : i_prdata;
      end else if (cnt_q == CNT_LAST) begin
        state_d = RESP;
        err_d   = 1'b1;
        tmo_d   = 1'b1;
        rdata_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      RESP: if (i_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign o_cmd_ready = state_q == IDLE;
  assign o_psel      = (state_q == SETUP) || (state_q == ACCESS);
  assign o_penable   = state_q == ACCESS;
  assign o_rsp_valid = state_q == RESP;
  assign o_rsp_rdata = rdata_q;
  assign o_rsp_err   = err_q;
  assign o_rsp_tmo   = tmo_q;
  assign o_paddr     = addr_q;
  assign o_pwrite    = write_q;
  assign o_pwdata    = wdata_q;
  assign o_pstrb     = strb_q;
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed APB transfers; expected responses queued at issue and
// checked by a monitor on each response handshake.
module tb_apb_master;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int TMO = 16;
  localparam int SW = DW / 8;

  logic          pclk = 1'b0;
  logic          preset = 1'b1;
  logic          i_cmd_valid = 1'b0;
  logic          o_cmd_ready;
  logic          i_cmd_write = 1'b0;
  logic [AW-1:0] i_cmd_addr = '0;
  logic [DW-1:0] i_cmd_wdata = '0;
  logic [SW-1:0] i_cmd_strb = '0;
  logic          o_rsp_valid;
  logic          i_rsp_ready = 1'b1;
  logic [DW-1:0] o_rsp_rdata;
  logic          o_rsp_err;
  logic          o_rsp_tmo;
  logic [AW-1:0] o_paddr;
  logic          o_pwrite;
  logic          o_psel;
  logic          o_penable;
  logic [DW-1:0] o_pwdata;
  logic [SW-1:0] o_pstrb;
  logic [DW-1:0] i_prdata = '0;
  logic          i_pslverr = 1'b0;
  logic          i_pready = 1'b0;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
    logic          tmo;
  } rsp_t;
  rsp_t exp_q[$];
  int n_chk = 0;
  int n_fail = 0;

  apb_master #(.DW(DW), .AW(AW), .TMO(TMO)) dut (
    .pclk(pclk), .preset(preset),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
    .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata), .i_cmd_strb(i_cmd_strb),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata),
    .o_rsp_err(o_rsp_err), .o_rsp_tmo(o_rsp_tmo),
    .o_paddr(o_paddr), .o_pwrite(o_pwrite), .o_psel(o_psel), .o_penable(o_penable),
    .o_pwdata(o_pwdata), .o_pstrb(o_pstrb),
    .i_prdata(i_prdata), .i_pslverr(i_pslverr), .i_pready(i_pready)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge pclk) begin
    #1;
    if (!preset && o_rsp_valid && i_rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_rsp: got rdata %0h err %0b tmo %0b with no pending command",
                 o_rsp_rdata, o_rsp_err, o_rsp_tmo);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_rdata", o_rsp_rdata, e.rdata);
        chk("rsp_err", o_rsp_err, e.err);
        chk("rsp_tmo", o_rsp_tmo, e.tmo);
      end
    end
  end

  // Called at a negedge in IDLE; returns at the negedge after the response handshake.
  // waits < 0 keeps i_pready low forever; hold > 0 back-pressures RESP with a new command pending.
  task automatic xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      input logic [SW-1:0] sb, input int waits, input logic err_rdy,
                      input logic err_wait, input logic [DW-1:0] rd, input int exp_access,
                      input logic [DW-1:0] exp_rdata, input logic exp_err, input logic exp_tmo,
                      input int hold);
    int n;
    chk("cmd_ready_idle", o_cmd_ready, 1);
    exp_q.push_back('{rdata: exp_rdata, err: exp_err, tmo: exp_tmo});
    i_cmd_valid = 1'b1;
    i_cmd_write = wr;
    i_cmd_addr  = a;
    i_cmd_wdata = wd;
    i_cmd_strb  = sb;
    @(negedge pclk);
    i_cmd_valid = 1'b0;
    chk("setup_sel_en", {o_psel, o_penable}, 2'b10);
    chk("setup_cmd_ready", o_cmd_ready, 0);
    chk("paddr", o_paddr, a);
    chk("pwrite", o_pwrite, wr);
    chk("pwdata", o_pwdata, wr ? wd : '0);
    chk("pstrb", o_pstrb, wr ? sb : '0);
    i_pready  = 1'b1;
    i_pslverr = 1'b1;
    i_prdata  = 32'hBAD0_BAD0;
    n = 0;
    repeat (TMO + 3) begin
      @(negedge pclk);
      if (!(o_psel && o_penable)) break;
      n++;
      if (n == 1 || o_paddr !== a || o_pstrb !== (wr ? sb : '0))
        chk("access_bus_stable", {o_paddr, o_pstrb}, {a, (wr ? sb : SW'(0))});
      i_pready  = (waits >= 0) && (n == waits + 1);
      i_pslverr = i_pready ? err_rdy : err_wait;
      i_prdata  = i_pready ? rd : 32'h1234_5678;
    end
    i_pready  = 1'b0;
    i_pslverr = 1'b0;
    chk("access_cycles", n, exp_access);
    chk("resp_valid", o_rsp_valid, 1);
    chk("resp_psel", {o_psel, o_penable}, 2'b00);
    if (hold > 0) begin
      i_rsp_ready = 1'b0;
      i_cmd_valid = 1'b1;
      repeat (hold) begin
        chk("hold_state", {o_rsp_valid, o_cmd_ready, o_psel}, 3'b100);
        chk("hold_rsp", {o_rsp_rdata, o_rsp_err, o_rsp_tmo}, {exp_rdata, exp_err, exp_tmo});
        @(negedge pclk);
      end
      i_rsp_ready = 1'b1;
    end
    @(negedge pclk);
    chk("cmd_ready_after", o_cmd_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #1;
    chk("rst_cmd_ready", o_cmd_ready, 1);
    chk("rst_outs", {o_rsp_valid, o_psel, o_penable, o_pwrite, o_rsp_err, o_rsp_tmo}, 0);
    chk("rst_data", {o_paddr, o_pwdata, o_pstrb, o_rsp_rdata}, 0);
    repeat (2) @(negedge pclk);
    preset = 1'b0;
    @(negedge pclk);
    // zero-wait write
    xfer(1, 5'h08, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 32'h5555_AAAA, 1, 32'h0, 0, 0, 0);
    // read with two wait states
    xfer(0, 5'h0C, 32'hFFFF_FFFF, 4'hF, 2, 0, 0, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF, 0, 0, 0);
    // slave error on the ready cycle
    xfer(1, 5'h10, 32'h0000_1111, 4'h3, 0, 1, 0, 32'h0, 1, 32'h0, 1, 0, 0);
    // slave error only on non-ready cycles is ignored
    xfer(1, 5'h10, 32'h0000_2222, 4'hC, 2, 0, 1, 32'h0, 3, 32'h0, 0, 0, 0);
    // ready never arrives: watchdog abort
    xfer(0, 5'h14, 32'h0, 4'h0, -1, 0, 0, 32'h0, TMO, 32'h0, 1, 1, 0);
    // ready coincides with the final watchdog cycle: normal completion wins
    xfer(0, 5'h18, 32'h0, 4'h0, TMO - 1, 0, 0, 32'h0BAD_F00D, TMO, 32'h0BAD_F00D, 0, 0, 0);
    // back-pressured response with the next command already pending
    xfer(0, 5'h04, 32'h0, 4'h0, 1, 1, 0, 32'hA5A5_5A5A, 2, 32'hA5A5_5A5A, 1, 0, 5);
    xfer(1, 5'h1C, 32'h0102_0304, 4'h5, 0, 0, 0, 32'h0, 1, 32'h0, 0, 0, 0);
    // asynchronous reset in mid-ACCESS discards the transfer
    i_cmd_valid = 1'b1;
    i_cmd_write = 1'b0;
    i_cmd_addr  = 5'h0C;
    @(negedge pclk);
    i_cmd_valid = 1'b0;
    i_pready = 1'b0;
    repeat (2) @(negedge pclk);
    chk("pre_rst_access", {o_psel, o_penable}, 2'b11);
    #2 preset = 1'b1;
    #1;
    chk("async_rst_bus", {o_psel, o_penable, o_rsp_valid}, 3'b000);
    chk("async_rst_ready", o_cmd_ready, 1);
    @(negedge pclk);
    preset = 1'b0;
    i_pready = 1'b1;
    repeat (4) begin
      @(negedge pclk);
      chk("post_rst_quiet", {o_rsp_valid, o_psel, o_cmd_ready}, 3'b001);
    end
    i_pready = 1'b0;
    xfer(0, 5'h08, 32'h0, 4'h0, 0, 0, 0, 32'h7777_8888, 1, 32'h7777_8888, 0, 0, 0);
    repeat (2) @(negedge pclk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
